// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO multiply/divide unit beside the ALU (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: MTHI/MTLO write HI/LO at the accept edge; MULT*/DIV* finish 33 edges after accept; divide-by-zero finishes after 1 edge.
// Backpressure: busy is high while an operation is in flight; start is dropped, not queued, unless the unit is idle.
// Build option: define MULDIV_FAST_MULT_EN for a single-cycle combinational MULT/MULTU (divide stays iterative).
module hilo_muldiv_unit #(
   parameter int DATA_W      = 32,
   parameter int ITER_CYCLES = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [5:0]        operation,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int MSB = DATA_W - 1;

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   // Counter value seen on the last iteration edge; the next edge is FIX.
   localparam logic [4:0] LAST_ITER = 5'(ITER_CYCLES - 1);

   logic [2:0]          state;
   logic [4:0]          cnt;
   logic [DATA_W-1:0]   op_a;       // multiplicand magnitude / divisor is op_b
   logic [DATA_W-1:0]   op_b;
   logic                neg_q;      // product or quotient needs negation
   logic                neg_r;      // remainder needs negation (dividend sign)
   logic                is_div;
   logic [2*DATA_W-1:0] mul_acc;    // {partial product, remaining multiplier bits}
   logic [DATA_W-1:0]   div_rem;
   logic [DATA_W-1:0]   div_quo;    // dividend bits shift out the top, quotient bits in the bottom

   logic                is_signed;
   logic [DATA_W-1:0]   mag_a;
   logic [DATA_W-1:0]   mag_b;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic                div_ge;
   logic [2*DATA_W-1:0] mul_raw;
   logic [2*DATA_W-1:0] mul_fixed;
   logic [DATA_W-1:0]   quo_fixed;
   logic [DATA_W-1:0]   rem_fixed;

   // Operand magnitudes: signed ops work on |a|,|b| and fix the sign at the end.
   always_comb begin
      is_signed = (operation == OP_MULT) || (operation == OP_DIV);
      mag_a     = (is_signed && a[MSB]) ? -a : a;
      mag_b     = (is_signed && b[MSB]) ? -b : b;
   end

   // One shift-add multiply step and one restoring-divide step.
   always_comb begin
      mul_sum   = {1'b0, mul_acc[2*DATA_W-1:DATA_W]} + (mul_acc[0] ? {1'b0, op_a} : {(DATA_W+1){1'b0}});
      div_shift = {div_rem, div_quo[MSB]};
      div_diff  = div_shift - {1'b0, op_b};
      div_ge    = (div_shift >= {1'b0, op_b});
   end

`ifdef MULDIV_FAST_MULT_EN
   // Whole unsigned magnitude product in one cycle from the latched operands.
   always_comb begin
      mul_raw = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
   end
`else
   // Iterative product is whatever the accumulator holds after the last step.
   always_comb begin
      mul_raw = mul_acc;
   end
`endif

   // Two's-complement sign correction applied when results are committed.
   always_comb begin
      mul_fixed = neg_q ? -mul_raw : mul_raw;
      quo_fixed = neg_q ? -div_quo : div_quo;
      rem_fixed = neg_r ? -div_rem : div_rem;
   end

   // Control FSM, iteration datapath and architectural HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         op_a        <= '0;
         op_b        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         is_div      <= 1'b0;
         mul_acc     <= '0;
         div_rem     <= '0;
         div_quo     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (operation)
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     OP_MULT, OP_MULTU: begin
                        op_a    <= mag_a;
                        op_b    <= mag_b;
                        neg_q   <= is_signed & (a[MSB] ^ b[MSB]);
                        neg_r   <= 1'b0;
                        is_div  <= 1'b0;
                        mul_acc <= {{DATA_W{1'b0}}, mag_b};
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        op_a    <= mag_a;
                        op_b    <= mag_b;
                        neg_q   <= is_signed & (a[MSB] ^ b[MSB]);
                        neg_r   <= is_signed & a[MSB];
                        is_div  <= 1'b1;
                        div_rem <= '0;
                        div_quo <= mag_a;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        // A zero divisor skips iteration and leaves HI/LO untouched.
                        state   <= (b == '0) ? S_FIN : S_DIV;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
               {hi, lo} <= mul_fixed;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= S_IDLE;
`else
               mul_acc <= {mul_sum, mul_acc[DATA_W-1:1]};
               cnt     <= cnt + 5'd1;
               if (cnt == LAST_ITER) state <= S_FIX;
`endif
            end
            S_DIV: begin
               if (div_ge) begin
                  div_rem <= div_diff[DATA_W-1:0];
                  div_quo <= {div_quo[DATA_W-2:0], 1'b1};
               end else begin
                  div_rem <= div_shift[DATA_W-1:0];
                  div_quo <= {div_quo[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
               if (cnt == LAST_ITER) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  lo <= quo_fixed;
                  hi <= rem_fixed;
               end else begin
                  {hi, lo} <= mul_fixed;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            S_FIN: begin
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide unit in the execute stage, beside the ALU. It takes the same 6-bit function code and 32-bit operands the ALU receives. It handles MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers. HI/LO outputs feed the ALU operand path for MFHI/MFLO. The pipeline stalls on busy.

Parameters:
DATA_W, 32, operand/HI/LO width; only 32 is supported.
ITER_CYCLES, 32, iteration count for shift-add multiply and restoring divide; must equal DATA_W.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe, sampled on the rising edge
operation  input  6  function code: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO
a  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source)
b  input  32  rt operand (multiplier/divisor)
busy  output  1  multi-cycle operation in flight; pipeline stalls
done  output  1  one-cycle pulse when HI/LO are updated by MULT*/DIV*
div_by_zero  output  1  one-cycle pulse, coincident with done, when the divisor was 0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Any in-flight operation is discarded.
- States: IDLE, MUL, DIV, FIX, FIN.
- Acceptance: start=1 and state=IDLE. start while busy=1 is ignored with no queueing. Unrecognised codes are ignored.
- MTHI/MTLO: accepted in IDLE; hi<=a or lo<=a at that edge. No busy, no done.
- MULT*/DIV* acceptance edge (E0):
  - Latch magnitudes |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the 5-bit iteration counter; busy<=1.
- MUL: one shift-add step per cycle over a 64-bit accumulator. Counter increments each cycle; after ITER_CYCLES steps (edges E1..E32), go to FIX.
- DIV: restoring divide, one quotient bit per cycle (E1..E32), 33-bit partial remainder, then FIX.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- FIX (edge E33):
  - Apply two's-complement sign correction.
  - MUL: {hi,lo}<=64-bit product.
  - DIV: lo<=quotient, hi<=remainder.
  - busy<=0; done<=1 for one cycle; state<=IDLE.
- Divisor=0 at acceptance: go to FIN. Edge E1: done=1 and div_by_zero=1 for one cycle, busy<=0, hi/lo unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Wrap-around, no flag.
- hi/lo hold their previous values throughout busy; only FIX/MTHI/MTLO/reset write them.
- A new start may be accepted on the same edge that done is asserted.

Optional Feature:
MULDIV_FAST_MULT_EN:
- Defined: MULT/MULTU compute a combinational 32x32 signed/unsigned product, registered at E0+1. busy is high for one cycle; done pulses at E1. DIV is unchanged.
- Undefined: the 33-edge iterative multiply described above.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high E0..E32, done at E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; with MULDIV_FAST_MULT_EN, done at E1 with the same values.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- DIVU a=100, b=0 with prior hi=0x11, lo=0x22 -> done and div_by_zero pulse at E1; hi=0x11, lo=0x22 retained.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. MTLO a=0x5 issued at E5 while busy -> ignored, lo stays 0x80000000 after completion.
- Start DIV 1000/7; assert reset at E10 -> busy=0, hi=lo=0 immediately. Then MTHI a=0xABCD -> hi=0xABCD next edge, busy stays 0.
